// File: rtl/mult_bist_array_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_bist_array_if
// Purpose  : Start/abort handshake and result bus of the multiplier BIST array.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_bist_array_if #(
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] expected_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  // Test controller side
  modport master (
    output start, abort, expected_sig,
    input  busy, done, pass, signature
  );

  // BIST engine side
  modport slave (
    input  start, abort, expected_sig,
    output busy, done, pass, signature
  );
endinterface
`default_nettype wire

// File: rtl/mult_bist_array.sv
`default_nettype none
// ============================================================================
// Module   : mult_bist_array
// Purpose  : LFSR-driven self-test of LANES pipelined multipliers, compacted
//            into a MISR signature with start/abort/done/pass handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mult_bist_array #(
  parameter int               WIDTH        = 8,
  parameter int               LANES        = 4,
  parameter int               PIPE         = 2,
  parameter int               NUM_PATTERNS = 64,
  parameter int               SIG_W        = 16,
  parameter logic [SIG_W-1:0] SIG_POLY     = SIG_W'(16'h1021),
  parameter logic [31:0]      SEED         = 32'h0000_ACE1
) (
  input  logic             clk,
  input  logic             reset,
  mult_bist_array_if.slave bus
);

  localparam int                 c_PW        = 2 * WIDTH;
  localparam int                 c_NSL       = (c_PW + SIG_W - 1) / SIG_W;
  localparam int                 c_CNT_W     = $clog2(NUM_PATTERNS + 1);
  localparam logic [31:0]        c_LFSR_POLY = 32'h8020_0003;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(NUM_PATTERNS - 1);
  localparam logic [PIPE-1:0]    c_VLD_LAST  = PIPE'(1) << (PIPE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_lfsr;
  logic [SIG_W-1:0]   r_misr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [PIPE-1:0]    r_vld;
  logic [c_PW-1:0]    r_pipe [PIPE][LANES];

  logic [WIDTH-1:0]       w_lo;
  logic [WIDTH-1:0]       w_hi;
  logic [WIDTH-1:0]       w_a    [LANES];
  logic [WIDTH-1:0]       w_b    [LANES];
  logic [c_PW-1:0]        w_prod [LANES];
  logic [c_PW-1:0]        w_xor;
  logic [c_NSL*SIG_W-1:0] w_ext;
  logic [SIG_W-1:0]       w_fold;
  logic [31:0]            w_lfsr_nxt;
  logic                   w_busy;
  logic                   w_idle_or_done;
  logic                   w_abort_act;
  logic                   w_start_act;
  logic                   w_issue;
  logic                   w_out_vld;
  logic                   w_drain_end;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int n);
    logic [2*WIDTH-1:0] d;
    d = {x, x} << (n % WIDTH);
    return d[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> (n % WIDTH);
    return d[WIDTH-1:0];
  endfunction

  // Control decode: abort beats start, and start is only honoured when not busy
  assign w_busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_abort_act    = bus.abort && w_busy;
  assign w_start_act    = bus.start && !bus.abort && w_idle_or_done;
  assign w_issue        = (r_state == ST_RUN) && !bus.abort;
  assign w_out_vld      = r_vld[PIPE-1];
  assign w_drain_end    = (r_vld == c_VLD_LAST);

  assign w_lo       = r_lfsr[WIDTH-1:0];
  assign w_hi       = r_lfsr[2*WIDTH-1:WIDTH];
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_POLY : 32'h0);

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_a[i]    = rotl(w_lo, i);
      assign w_b[i]    = rotr(w_hi, i);
      assign w_prod[i] = {{WIDTH{1'b0}}, w_a[i]} * {{WIDTH{1'b0}}, w_b[i]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int s = 0; s < PIPE; s++) begin
        for (int l = 0; l < LANES; l++) begin
          r_pipe[s][l] <= '0;
        end
      end
    end else begin
      if (w_abort_act) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_issue;
        for (int s = 1; s < PIPE; s++) begin
          r_vld[s] <= r_vld[s-1];
        end
      end
      for (int l = 0; l < LANES; l++) begin
        if (w_issue) begin
          r_pipe[0][l] <= w_prod[l];
        end
        for (int s = 1; s < PIPE; s++) begin
          r_pipe[s][l] <= r_pipe[s-1][l];
        end
      end
    end
  end

  // Fold the lane XOR into SIG_W-bit slices; the top slice is zero-extended
  always_comb begin
    w_xor  = '0;
    w_ext  = '0;
    w_fold = '0;
    for (int l = 0; l < LANES; l++) begin
      w_xor = w_xor ^ r_pipe[PIPE-1][l];
    end
    w_ext[c_PW-1:0] = w_xor;
    for (int s = 0; s < c_NSL; s++) begin
      w_fold = w_fold ^ w_ext[s*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
      r_misr <= '0;
      r_cnt  <= '0;
    end else if (w_start_act) begin
      r_lfsr <= SEED;
      r_misr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_issue) begin
        r_lfsr <= w_lfsr_nxt;
        r_cnt  <= r_cnt + c_CNT_W'(1);
      end
      if (w_out_vld && !w_abort_act) begin
        r_misr <= {r_misr[SIG_W-2:0], 1'b0}
                ^ (r_misr[SIG_W-1] ? SIG_POLY : '0)
                ^ w_fold;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_act) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort)                w_state_nxt = ST_IDLE;
        else if (r_cnt == c_CNT_LAST) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)        w_state_nxt = ST_IDLE;
        else if (w_drain_end) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.pass      = (r_state == ST_DONE) && (r_misr == bus.expected_sig);
  assign bus.signature = r_misr;

endmodule
`default_nettype wire
